// File: rtl/execute_pkg.sv
// Shared types and helpers for the execute writeback merge.
// Holds the fixed-width entry tail and the channel-index width helper.
package execute_pkg;

  localparam int CMTD_W = 4;

  typedef struct packed {
    logic [CMTD_W-1:0] cmtdelay;
    logic              lsmiss;
  } wb_tail_t;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/execute_wb_fifo.sv
// Per-channel result queue for the writeback merge.
// Circular buffer with wrapping pointers and a flush.
module execute_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;

  logic [W-1:0]    mem_q [DEPTH];
  logic [PW-1:0]   wr_q, rd_q;
  logic [CNTW-1:0] cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      if (push && !pop)
        cnt_q <= cnt_q + CNTW'(1);
      else if (pop && !push)
        cnt_q <= cnt_q - CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_q] <= wdata;
  end

  assign rdata = mem_q[rd_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNTW'(DEPTH));

endmodule

// File: rtl/execute_wb_merge.sv
// Merges functional-unit results into one writeback stream.
// Round-robin over per-channel queues into a single output register.
module execute_wb_merge
  import execute_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 4,
  parameter int ROB_W  = 4,
  parameter int FID_W  = 8,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       bco_valid,
  input  logic [NUM_CH-1:0]          i_valid,
  output logic [NUM_CH-1:0]          o_ready,
  input  logic [NUM_CH*ROB_W-1:0]    i_dst_rob,
  input  logic [NUM_CH*FID_W-1:0]    i_fid,
  input  logic [NUM_CH*DATA_W-1:0]   i_result,
  input  logic [NUM_CH*CMTD_W-1:0]   i_cmtdelay,
  input  logic [NUM_CH-1:0]          i_lsmiss,
  input  logic                       i_ready,
  output logic                       o_valid,
  output logic [ROB_W-1:0]           o_dst_rob,
  output logic [FID_W-1:0]           o_fid,
  output logic [DATA_W-1:0]          o_result,
  output logic [CMTD_W-1:0]          o_cmtdelay,
  output logic                       o_lsmiss,
  output logic [ch_idx_w(NUM_CH)-1:0] o_src
);

  localparam int SW = ch_idx_w(NUM_CH);
  localparam int EW = ROB_W + FID_W + DATA_W + CMTD_W + 1;

  logic [NUM_CH-1:0] push, pop, empty, full;
  logic [EW-1:0]     wdata [NUM_CH];
  logic [EW-1:0]     rdata [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wdata[c] = {i_dst_rob[c*ROB_W +: ROB_W],
                       i_fid[c*FID_W +: FID_W],
                       i_result[c*DATA_W +: DATA_W],
                       i_cmtdelay[c*CMTD_W +: CMTD_W],
                       i_lsmiss[c]};
    execute_wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .flush  (bco_valid),
      .push   (push[c]),
      .pop    (pop[c]),
      .wdata  (wdata[c]),
      .rdata  (rdata[c]),
      .empty  (empty[c]),
      .full   (full[c])
    );
  end

  assign o_ready = ~full;
  assign push    = i_valid & ~full & {NUM_CH{~bco_valid}};

  logic [SW-1:0] rr_q, gnt, rr_nxt;
  logic          any, load;
  int            idx;

  // First non-empty channel scanning upward from rr_q.
  always_comb begin
    any = 1'b0;
    gnt = '0;
    idx = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(rr_q) + i) % NUM_CH;
      if (!any && !empty[idx]) begin
        any = 1'b1;
        gnt = SW'(idx);
      end
    end
  end

  logic valid_q;

  assign load   = (!valid_q || i_ready) && any && !bco_valid;
  assign rr_nxt = (gnt == SW'(NUM_CH - 1)) ? '0 : gnt + SW'(1);

  always_comb begin
    pop      = '0;
    pop[gnt] = load;
  end

  logic [ROB_W-1:0]  s_rob;
  logic [FID_W-1:0]  s_fid;
  logic [DATA_W-1:0] s_res;
  wb_tail_t          s_tail;

  assign {s_rob, s_fid, s_res, s_tail} = rdata[gnt];

  logic [ROB_W-1:0]  rob_q;
  logic [FID_W-1:0]  fid_q;
  logic [DATA_W-1:0] res_q;
  logic [CMTD_W-1:0] cd_q;
  logic              ls_q;
  logic [SW-1:0]     src_q;

  // Fields are zeroed whenever nothing is held so siblings can OR-merge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      rob_q   <= '0;
      fid_q   <= '0;
      res_q   <= '0;
      cd_q    <= '0;
      ls_q    <= 1'b0;
      src_q   <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      rob_q   <= s_rob;
      fid_q   <= s_fid;
      res_q   <= s_res;
      cd_q    <= s_tail.cmtdelay;
      ls_q    <= s_tail.lsmiss;
      src_q   <= gnt;
    end else if (bco_valid || i_ready) begin
      valid_q <= 1'b0;
      rob_q   <= '0;
      fid_q   <= '0;
      res_q   <= '0;
      cd_q    <= '0;
      ls_q    <= 1'b0;
      src_q   <= '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   rr_q <= '0;
    else if (load) rr_q <= rr_nxt;
  end

  assign o_valid    = valid_q;
  assign o_dst_rob  = rob_q;
  assign o_fid      = fid_q;
  assign o_result   = res_q;
  assign o_cmtdelay = cd_q;
  assign o_lsmiss   = ls_q;
  assign o_src      = src_q;

endmodule

// File: tb/tb_execute_wb_merge.sv
// Scoreboard bench for execute_wb_merge.
// Stimulus queues expected results; a negedge monitor checks them.
module tb_execute_wb_merge;

  logic        clk, resetn, bco_valid, i_ready;
  logic [3:0]  i_valid, o_ready, i_lsmiss;
  logic [15:0] i_dst_rob, i_cmtdelay;
  logic [31:0] i_fid;
  logic [127:0] i_result;
  logic        o_valid, o_lsmiss;
  logic [3:0]  o_dst_rob, o_cmtdelay;
  logic [7:0]  o_fid;
  logic [31:0] o_result;
  logic [1:0]  o_src;

  execute_wb_merge dut (
    .clk(clk), .resetn(resetn), .bco_valid(bco_valid),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_dst_rob(i_dst_rob), .i_fid(i_fid), .i_result(i_result),
    .i_cmtdelay(i_cmtdelay), .i_lsmiss(i_lsmiss), .i_ready(i_ready),
    .o_valid(o_valid), .o_dst_rob(o_dst_rob), .o_fid(o_fid),
    .o_result(o_result), .o_cmtdelay(o_cmtdelay),
    .o_lsmiss(o_lsmiss), .o_src(o_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  src;
    logic [3:0]  rob;
    logic [7:0]  fid;
    logic [31:0] res;
    logic [3:0]  cd;
    logic        ls;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output src=%0d result=%0h required=none",
                   o_src, o_result);
        end else begin
          e = sb.pop_front();
          chk("out_src", 64'(o_src), 64'(e.src));
          chk("out_rob", 64'(o_dst_rob), 64'(e.rob));
          chk("out_fid", 64'(o_fid), 64'(e.fid));
          chk("out_result", 64'(o_result), 64'(e.res));
          chk("out_cmtdelay", 64'(o_cmtdelay), 64'(e.cd));
          chk("out_lsmiss", 64'(o_lsmiss), 64'(e.ls));
        end
      end else if (!o_valid) begin
        chk("idle_zero",
            64'({o_dst_rob, o_fid, o_result, o_cmtdelay, o_lsmiss, o_src}),
            64'(0));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    i_valid = '0; i_dst_rob = '0; i_fid = '0;
    i_result = '0; i_cmtdelay = '0; i_lsmiss = '0;
  endtask

  task automatic drive(input int ch, input logic [3:0] rob,
                       input logic [7:0] fid, input logic [31:0] res,
                       input logic [3:0] cd, input logic ls,
                       input bit expect_it);
    i_valid[ch] = 1'b1;
    i_dst_rob[ch*4 +: 4] = rob;
    i_fid[ch*8 +: 8] = fid;
    i_result[ch*32 +: 32] = res;
    i_cmtdelay[ch*4 +: 4] = cd;
    i_lsmiss[ch] = ls;
    if (expect_it)
      sb.push_back('{src: 2'(ch), rob: rob, fid: fid, res: res,
                     cd: cd, ls: ls});
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    bco_valid = 1'b0;
    i_ready = 1'b1;
    clear_in();
    repeat (2) step();
    sb.delete();
    resetn = 1'b1;
    step();
  endtask

  task automatic drain(input string nm, input int maxc);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin
      step();
      n++;
    end
    chk(nm, 64'(sb.size()), 64'(0));
  endtask

  initial begin
    logic [3:0] rdy;
    int a0, a3, guard;
    resetn = 1'b0;
    bco_valid = 1'b0;
    i_ready = 1'b1;
    clear_in();
    repeat (3) step();
    chk("rst_valid", 64'(o_valid), 64'(0));
    chk("rst_ready", 64'(o_ready), 64'hF);
    chk("rst_src", 64'(o_src), 64'(0));
    chk("rst_result", 64'(o_result), 64'(0));
    resetn = 1'b1;
    step();

    // single push, two-edge latency, one-cycle output
    drive(2, 4'd5, 8'h21, 32'h1234, 4'd3, 1'b0, 1);
    step();
    clear_in();
    chk("lat_edge1", 64'(o_valid), 64'(0));
    step();
    chk("lat_edge2", 64'(o_valid), 64'(1));
    chk("lat_src", 64'(o_src), 64'(2));
    chk("lat_result", 64'(o_result), 64'h1234);
    step();
    chk("lat_one_cycle", 64'(o_valid), 64'(0));
    drain("drain_single", 5);

    // all four channels in one cycle
    do_reset();
    for (int c = 0; c < 4; c++)
      drive(c, 4'(c + 8), 8'(8'h40 + c), 32'hB0 + c, 4'(c), c[0], 1);
    step();
    clear_in();
    for (int k = 0; k < 4; k++) begin
      step();
      chk("all4_valid", 64'(o_valid), 64'(1));
      chk("all4_src", 64'(o_src), 64'(k));
    end
    step();
    chk("all4_done", 64'(o_valid), 64'(0));
    drain("drain_all4", 5);

    // backpressure and full queue
    do_reset();
    i_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(0, 4'(k), 8'(8'h30 + k), 32'hA000 + k, 4'(k), k[0], 1);
      step();
      clear_in();
    end
    chk("bp_valid", 64'(o_valid), 64'(1));
    chk("bp_result", 64'(o_result), 64'hA000);
    chk("bp_ready", 64'(o_ready), 64'hE);
    drive(0, 4'hF, 8'hFF, 32'hDEAD, 4'hF, 1'b1, 0);
    step();
    clear_in();
    chk("bp_ready_after6", 64'(o_ready), 64'hE);
    chk("bp_hold_result", 64'(o_result), 64'hA000);
    chk("bp_hold_rob", 64'(o_dst_rob), 64'(0));
    i_ready = 1'b1;
    drain("drain_bp", 20);
    repeat (3) step();
    chk("bp_empty", 64'(o_valid), 64'(0));

    // flush with queued data and a same-cycle push
    do_reset();
    i_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++)
        drive(c, 4'(r), 8'(r), 32'(c * 16 + r), 4'(r), 1'b0, 0);
      step();
      clear_in();
    end
    chk("fl_pre_valid", 64'(o_valid), 64'(1));
    bco_valid = 1'b1;
    drive(1, 4'd9, 8'h99, 32'h9999, 4'd9, 1'b1, 0);
    step();
    bco_valid = 1'b0;
    clear_in();
    chk("fl_valid", 64'(o_valid), 64'(0));
    chk("fl_ready", 64'(o_ready), 64'hF);
    i_ready = 1'b1;
    repeat (8) step();
    chk("fl_quiet", 64'(o_valid), 64'(0));

    // asynchronous reset while holding an output
    do_reset();
    i_ready = 1'b0;
    drive(1, 4'd7, 8'h77, 32'h7777, 4'd7, 1'b1, 0);
    step();
    clear_in();
    step();
    chk("ar_pre_valid", 64'(o_valid), 64'(1));
    @(negedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("ar_valid", 64'(o_valid), 64'(0));
    chk("ar_result", 64'(o_result), 64'(0));
    chk("ar_rob", 64'(o_dst_rob), 64'(0));
    chk("ar_src", 64'(o_src), 64'(1) & 64'(o_src) ^ 64'(o_src));
    chk("ar_ready", 64'(o_ready), 64'hF);
    step();
    resetn = 1'b1;
    i_ready = 1'b1;
    step();

    // two always-busy channels must alternate
    do_reset();
    for (int j = 0; j < 12; j++)
      sb.push_back('{src: (j % 2) ? 2'd3 : 2'd0, rob: 4'(j / 2),
                     fid: 8'(8'h60 + j / 2),
                     res: ((j % 2) ? 32'h3000 : 32'h0) + 32'(j / 2),
                     cd: 4'(j / 2), ls: 1'b0});
    a0 = 0; a3 = 0; guard = 0;
    while ((a0 < 6 || a3 < 6) && guard < 100) begin
      clear_in();
      if (a0 < 6) drive(0, 4'(a0), 8'(8'h60 + a0), 32'(a0), 4'(a0), 1'b0, 0);
      if (a3 < 6) drive(3, 4'(a3), 8'(8'h60 + a3), 32'h3000 + 32'(a3),
                        4'(a3), 1'b0, 0);
      rdy = o_ready;
      step();
      if (a0 < 6 && rdy[0]) a0++;
      if (a3 < 6 && rdy[3]) a3++;
      guard++;
    end
    clear_in();
    chk("rr_stim_done", 64'(guard < 100), 64'(1));
    drain("drain_rr", 40);
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
